// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the fetch-side capture signals, the decode-side head/handshake
//   signals and the queue occupancy of fetch_queue.
//   master : driven by the fetch/decode environment (provides fetch triple,
//            fetchEnable, flush, decodeReady; observes head and PCWrite)
//   slave  : the queue itself
//   Parameter AW: pointer width, count is AW+1 bits wide.
interface fetch_queue_if #(
  parameter int AW = 2
);
  logic [15:0] PCIn;
  logic [15:0] IRIn;
  logic [15:0] incPCIn;
  logic        fetchEnable;
  logic        flush;
  logic        decodeReady;
  logic        PCWrite;
  logic        validOut;
  logic [15:0] PCOut;
  logic [15:0] IROut;
  logic [15:0] incPCOut;
  logic [AW:0] count;

  modport master (
    output PCIn, IRIn, incPCIn, fetchEnable, flush, decodeReady,
    input  PCWrite, validOut, PCOut, IROut, incPCOut, count
  );

  modport slave (
    input  PCIn, IRIn, incPCIn, fetchEnable, flush, decodeReady,
    output PCWrite, validOut, PCOut, IROut, incPCOut, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction queue between fetch and decode. Captures {PC, IR, PC+1}
//   whenever fetch is allowed to advance, holds up to DEPTH entries and
//   presents the oldest one to decode with a valid/ready handshake. It also
//   drives the fetch PC write enable, acting as fetch backpressure, and
//   supports a single-cycle flush for branch/jump redirect.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (clears pointers and count;
//           storage is left as is)
//   fq    - fetch_queue_if.slave: fetch triple, fetchEnable, flush,
//           decodeReady in; PCWrite, validOut, head triple, count out
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave fq
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [47:0]   entryMem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;
  logic [47:0]   headEntry;

  assign full  = (cnt == FULL_COUNT);
  assign empty = (cnt == {(AW+1){1'b0}});

  // Full blocks enqueue even when the head leaves this cycle, which keeps
  // decodeReady out of the PCWrite path.
  assign enq = fq.fetchEnable & ~full & ~fq.flush;
  assign deq = ~empty & fq.decodeReady & ~fq.flush;

  // Flush must load the redirected PC regardless of fullness.
  assign fq.PCWrite  = fq.flush | (fq.fetchEnable & ~full);
  assign fq.validOut = ~empty;
  assign fq.count    = cnt;

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      entryMem[wp] <= {fq.PCIn, fq.IRIn, fq.incPCIn};
    end
  end

  // Pointer and occupancy state; flush and reset both empty the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= {AW{1'b0}};
      rp  <= {AW{1'b0}};
      cnt <= {(AW+1){1'b0}};
    end else if (fq.flush) begin
      wp  <= {AW{1'b0}};
      rp  <= {AW{1'b0}};
      cnt <= {(AW+1){1'b0}};
    end else begin
      if (enq) begin
        wp <= wp + AW'(1);
      end
      if (deq) begin
        rp <= rp + AW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head presentation; an empty queue shows an all-zero bubble.
  always_comb begin
    headEntry = entryMem[rp];
    if (empty) begin
      fq.PCOut    = 16'h0000;
      fq.IROut    = 16'h0000;
      fq.incPCOut = 16'h0000;
    end else begin
      fq.PCOut    = headEntry[47:32];
      fq.IROut    = headEntry[31:16];
      fq.incPCOut = headEntry[15:0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Self-checking bench for fetch_queue. A queue-of-entries reference model
//   is advanced at every rising edge from the inputs applied in that cycle;
//   each scenario task compares the DUT outputs against the model and
//   against the fixed values the scenarios call for.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [47:0] mq[$];

  fetch_queue_if #(.AW(AW)) ifc();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (rstN),
    .fq    (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] expPC();
    return (mq.size() != 0) ? mq[0][47:32] : 16'h0000;
  endfunction
  function automatic logic [15:0] expIR();
    return (mq.size() != 0) ? mq[0][31:16] : 16'h0000;
  endfunction
  function automatic logic [15:0] expInc();
    return (mq.size() != 0) ? mq[0][15:0] : 16'h0000;
  endfunction
  function automatic logic expPW();
    return ifc.flush | (ifc.fetchEnable & (mq.size() < DEPTH));
  endfunction

  task automatic drive(input logic fe, input logic fl, input logic dr,
                       input logic [15:0] pc, input logic [15:0] ir);
    ifc.fetchEnable = fe;
    ifc.flush       = fl;
    ifc.decodeReady = dr;
    ifc.PCIn        = pc;
    ifc.IRIn        = ir;
    ifc.incPCIn     = pc + 16'd1;
  endtask

  // Reference behaviour at a rising edge, from the inputs of the closing cycle.
  task automatic modelEdge();
    int  sz;
    bit  e;
    bit  d;
    logic [47:0] entry;
    sz = mq.size();
    if (!rstN || ifc.flush) begin
      mq.delete();
      return;
    end
    e = ifc.fetchEnable && (sz < DEPTH);
    d = (sz > 0) && ifc.decodeReady;
    entry = {ifc.PCIn, ifc.IRIn, ifc.incPCIn};
    if (d) void'(mq.pop_front());
    if (e) mq.push_back(entry);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000);
    #2;
    checks++; if (ifc.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ifc.count); end
    checks++; if (ifc.validOut !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifc.validOut); end
    checks++; if (ifc.PCOut !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", ifc.PCOut); end
    checks++; if (ifc.PCWrite !== 1'b1) begin errors++; $display("FAIL reset_pcwrite got %b exp 1", ifc.PCWrite); end
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000);
    rstN = 1'b1;
    #2;
    checks++; if (ifc.PCWrite !== 1'b0) begin errors++; $display("FAIL reset_pcwrite_fe0 got %b exp 0", ifc.PCWrite); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(i), 16'(16'h1000 + i));
      #2;
      checks++; if (ifc.PCWrite !== 1'b1) begin errors++; $display("FAIL stream_pcwrite[%0d] got %b exp 1", i, ifc.PCWrite); end
      tick();
    end
    #1;
    checks++; if (ifc.count !== 3'd4) begin errors++; $display("FAIL stream_count got %0d exp 4", ifc.count); end
    checks++; if (ifc.PCWrite !== 1'b0) begin errors++; $display("FAIL stream_full_pcwrite got %b exp 0", ifc.PCWrite); end
    checks++; if ({ifc.PCOut, ifc.IROut, ifc.incPCOut} !== {16'h0000, 16'h1000, 16'h0001})
      begin errors++; $display("FAIL stream_head got %h/%h/%h exp 0000/1000/0001", ifc.PCOut, ifc.IROut, ifc.incPCOut); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'h0099, 16'h0099);
      #2;
      checks++; if (ifc.PCOut !== 16'(i) || ifc.validOut !== 1'b1)
        begin errors++; $display("FAIL drain_pc[%0d] got %h v%b exp %h v1", i, ifc.PCOut, ifc.validOut, 16'(i)); end
      checks++; if (ifc.IROut !== expIR()) begin errors++; $display("FAIL drain_ir[%0d] got %h exp %h", i, ifc.IROut, expIR()); end
      tick();
    end
    #1;
    checks++; if (ifc.validOut !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b exp 0", ifc.validOut); end
    checks++; if ({ifc.PCOut, ifc.IROut, ifc.incPCOut} !== 48'h0)
      begin errors++; $display("FAIL drain_bubble got %h/%h/%h exp 0", ifc.PCOut, ifc.IROut, ifc.incPCOut); end
  endtask

  task automatic test_full_deq();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(16'h0020 + i), 16'(16'h2000 + i));
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 16'h0024, 16'h2024);
    #2;
    checks++; if (ifc.PCWrite !== 1'b0) begin errors++; $display("FAIL fulldeq_pcwrite got %b exp 0", ifc.PCWrite); end
    tick();
    #2;
    checks++; if (ifc.count !== 3'd3) begin errors++; $display("FAIL fulldeq_count got %0d exp 3", ifc.count); end
    checks++; if (ifc.PCWrite !== 1'b1) begin errors++; $display("FAIL fulldeq_pcwrite_next got %b exp 1", ifc.PCWrite); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(16'h0024 + i), 16'(16'h2024 + i));
      #2;
      checks++; if (ifc.PCOut !== expPC() || ifc.incPCOut !== expInc())
        begin errors++; $display("FAIL wrap_head[%0d] got %h/%h exp %h/%h", i, ifc.PCOut, ifc.incPCOut, expPC(), expInc()); end
      checks++; if (int'(ifc.count) !== mq.size()) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", i, ifc.count, mq.size()); end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b1, 16'h0030, 16'h3030);
    #2;
    checks++; if (ifc.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", ifc.count); end
    checks++; if (ifc.PCWrite !== 1'b1) begin errors++; $display("FAIL flush_pcwrite got %b exp 1", ifc.PCWrite); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'h0040, 16'h4040);
    #2;
    checks++; if (ifc.count !== 3'd0 || ifc.validOut !== 1'b0)
      begin errors++; $display("FAIL flush_empty got count %0d v%b exp 0 v0", ifc.count, ifc.validOut); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    checks++; if (ifc.PCOut !== 16'h0040 || ifc.validOut !== 1'b1 || ifc.IROut !== 16'h4040)
      begin errors++; $display("FAIL flush_redirect got %h/%h v%b exp 0040/4040 v1", ifc.PCOut, ifc.IROut, ifc.validOut); end
  endtask

  task automatic test_passthrough();
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(16'h0010 + i), 16'(16'h5010 + i));
      #2;
      if (i > 0) begin
        checks++; if (ifc.validOut !== 1'b1 || ifc.PCOut !== 16'(16'h0010 + i - 1) || ifc.count !== 3'd1)
          begin errors++; $display("FAIL pass[%0d] got %h v%b c%0d exp %h v1 c1", i, ifc.PCOut, ifc.validOut, ifc.count, 16'(16'h0010 + i - 1)); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0050, 16'h6050);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0051, 16'h6051);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    checks++; if (ifc.count !== 3'd2) begin errors++; $display("FAIL areset_pre_count got %0d exp 2", ifc.count); end
    rstN = 1'b0;
    mq.delete();
    #1;
    checks++; if (ifc.count !== 3'd0 || ifc.validOut !== 1'b0 || ifc.PCOut !== 16'h0000 || ifc.IROut !== 16'h0000)
      begin errors++; $display("FAIL areset_clear got c%0d v%b %h/%h exp c0 v0 0/0", ifc.count, ifc.validOut, ifc.PCOut, ifc.IROut); end
    rstN = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0077, 16'h7077);
    #1;
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    checks++; if (ifc.PCOut !== 16'h0077 || ifc.validOut !== 1'b1 || ifc.count !== 3'd1)
      begin errors++; $display("FAIL areset_first got %h v%b c%0d exp 0077 v1 c1", ifc.PCOut, ifc.validOut, ifc.count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom));
      #2;
      checks++; if (ifc.PCWrite !== expPW()) begin errors++; $display("FAIL rnd_pcwrite[%0d] got %b exp %b", i, ifc.PCWrite, expPW()); end
      checks++; if (ifc.validOut !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, ifc.validOut, mq.size() != 0); end
      checks++; if (int'(ifc.count) !== mq.size()) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, ifc.count, mq.size()); end
      checks++; if ({ifc.PCOut, ifc.IROut, ifc.incPCOut} !== {expPC(), expIR(), expInc()})
        begin errors++; $display("FAIL rnd_head[%0d] got %h/%h/%h exp %h/%h/%h", i, ifc.PCOut, ifc.IROut, ifc.incPCOut, expPC(), expIR(), expInc()); end
      tick();
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_drain();
    test_full_deq();
    test_flush();
    test_passthrough();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
